// File: rtl/des_pkg.sv
// des_pkg: shared DES permutation tables, key-shift schedule and rotate helpers.
// Latency: none (constants and pure functions only).
// Backpressure: not applicable.
//
// Table entries use FIPS 46-3 numbering: each entry is the 1-based source bit,
// where bit 1 is the MSB of the source vector.
package des_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } ks_state_t;

  // PC-1: 64-bit key -> 56-bit C||D (first 28 entries form C, last 28 form D).
  localparam int PC1_TBL [56] = '{
    57, 49, 41, 33, 25, 17,  9,
     1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,
    19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,
     7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,
    21, 13,  5, 28, 20, 12,  4
  };

  // PC-2: 56-bit C||D -> 48-bit round subkey.
  localparam int PC2_TBL [48] = '{
    14, 17, 11, 24,  1,  5,
     3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,
    16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,
    30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,
    46, 42, 50, 36, 29, 32
  };

  // Left-rotation amount applied to C and D before round 1..16.
  localparam int SHIFT_SCHED [16] = '{
    1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1
  };

  // Every schedule entry is 1 or 2, so a single select bit drives the rotators.
  function automatic logic shift_is_two(input logic [3:0] idx);
    return (SHIFT_SCHED[idx] == 2);
  endfunction

  function automatic logic [27:0] rol28(input logic [27:0] x, input logic two);
    return two ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
  endfunction

  function automatic logic [27:0] ror28(input logic [27:0] x, input logic two);
    return two ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
  endfunction

endpackage

// File: rtl/des_pc2.sv
// des_pc2: DES permuted choice 2, 56-bit C||D to 48-bit round subkey.
// Latency: combinational, zero cycles.
// Backpressure: none; pure wiring.
//
// Ports:
//   cd     [55:0] C in [55:28], D in [27:0]; FIPS bit 1 = cd[55]
//   subkey [47:0] PC-2 output; FIPS bit 1 = subkey[47]
module des_pc2
  import des_pkg::*;
(
  input  logic [55:0] cd,
  output logic [47:0] subkey
);

  for (genvar i = 0; i < 48; i++) begin : g_pc2
    assign subkey[47-i] = cd[56-PC2_TBL[i]];
  end

  // PC-2 drops C/D bits 9, 18, 22, 25, 35, 38, 43 and 54.
  logic unused_cd;
  assign unused_cd = ^{cd[47], cd[38], cd[34], cd[31], cd[21], cd[18], cd[13], cd[2]};

endmodule

// File: rtl/des_key_sched.sv
// des_key_sched: emits the 16 DES round subkeys, forward (encrypt) or reverse (decrypt).
// Latency: first subkey valid 1 cycle after i_start is sampled in IDLE; one subkey per handshake.
// Backpressure: valid/ready; C/D, o_round and o_subkey hold while i_ready is low.
//
// Ports:
//   i_clk, i_rst_n       clock (rising edge), async active-low reset
//   i_start, i_key,      start request with 64-bit key (FIPS bit 1 = i_key[63])
//   i_decrypt            and direction, all sampled only in IDLE
//   i_ready, i_abort     consumer accept, synchronous abort of a running sequence
//   o_subkey, o_round    current subkey (PC-2 of C/D) and its index 0..15 = K1..K16
//   o_valid, o_busy      both high while in RUN
//   o_done               one-cycle pulse after the 16th subkey is accepted
module des_key_sched
  import des_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_start,
  input  logic [63:0] i_key,
  input  logic        i_decrypt,
  input  logic        i_ready,
  input  logic        i_abort,
  output logic [47:0] o_subkey,
  output logic        o_valid,
  output logic [3:0]  o_round,
  output logic        o_busy,
  output logic        o_done
);

  ks_state_t   state;
  logic [27:0] c_reg;
  logic [27:0] d_reg;
  logic [3:0]  step;        // accepted handshakes in the current sequence
  logic        dec_mode;
  logic        done_pulse;

  // PC-1 of the incoming key.
  logic [55:0] pc1_cd;
  for (genvar i = 0; i < 56; i++) begin : g_pc1
    assign pc1_cd[55-i] = i_key[64-PC1_TBL[i]];
  end

  // Parity bits 8, 16, .., 64 never reach the schedule.
  logic unused_parity;
  assign unused_parity = ^{i_key[56], i_key[48], i_key[40], i_key[32],
                           i_key[24], i_key[16], i_key[8],  i_key[0]};

  // Rotation for the handshake that leaves the current step. Encrypt walks the
  // schedule forward from entry 1 (entry 0 was applied at load); decrypt walks
  // it backwards from entry 15 and undoes each left rotation with a right one.
  logic rot_two;
  always_comb begin
    rot_two = 1'b0;
    if (dec_mode) begin
      rot_two = shift_is_two(4'd15 - step);
    end else begin
      rot_two = shift_is_two(step + 4'd1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= ST_IDLE;
      c_reg      <= '0;
      d_reg      <= '0;
      step       <= '0;
      dec_mode   <= 1'b0;
      done_pulse <= 1'b0;
    end else begin
      done_pulse <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (i_start) begin
            dec_mode <= i_decrypt;
            step     <= '0;
            state    <= ST_RUN;
            // C0/D0 already gives K16 because the full schedule rotates by 28.
            if (i_decrypt) begin
              c_reg <= pc1_cd[55:28];
              d_reg <= pc1_cd[27:0];
            end else begin
              c_reg <= rol28(pc1_cd[55:28], shift_is_two(4'd0));
              d_reg <= rol28(pc1_cd[27:0],  shift_is_two(4'd0));
            end
          end
        end
        ST_RUN: begin
          if (i_abort) begin
            state <= ST_IDLE;
            step  <= '0;
          end else if (i_ready) begin
            if (step == 4'd15) begin
              state      <= ST_IDLE;
              step       <= '0;
              done_pulse <= 1'b1;
            end else begin
              step <= step + 4'd1;
              if (dec_mode) begin
                c_reg <= ror28(c_reg, rot_two);
                d_reg <= ror28(d_reg, rot_two);
              end else begin
                c_reg <= rol28(c_reg, rot_two);
                d_reg <= rol28(d_reg, rot_two);
              end
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  des_pc2 u_pc2 (
    .cd     ({c_reg, d_reg}),
    .subkey (o_subkey)
  );

  assign o_valid = (state == ST_RUN);
  assign o_busy  = (state == ST_RUN);
  assign o_done  = done_pulse;
  assign o_round = (state == ST_RUN) ? (dec_mode ? (4'd15 - step) : step) : 4'd0;

endmodule

// File: tb/tb_des_key_sched.sv
module tb_des_key_sched;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_start;
  logic [63:0] i_key;
  logic        i_decrypt;
  logic        i_ready;
  logic        i_abort;
  logic [47:0] o_subkey;
  logic        o_valid;
  logic [3:0]  o_round;
  logic        o_busy;
  logic        o_done;

  int total = 0;
  int bad   = 0;

  always #5 i_clk = ~i_clk;

  des_key_sched dut (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_start   (i_start),
    .i_key     (i_key),
    .i_decrypt (i_decrypt),
    .i_ready   (i_ready),
    .i_abort   (i_abort),
    .o_subkey  (o_subkey),
    .o_valid   (o_valid),
    .o_round   (o_round),
    .o_busy    (o_busy),
    .o_done    (o_done)
  );

  // Reference tables, FIPS 46-3 numbering (1-based, bit 1 = MSB).
  localparam int PC1_T [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };
  localparam int PC2_T [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };
  localparam int SCHED_T [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  localparam logic [63:0] K0 = 64'h133457799BBCDFF1;

  // exp_ks[r] = K(r+1) for the key last passed to build_model.
  logic [47:0] exp_ks [16];

  // Textbook schedule: Kr = PC2(C0 <<< s, D0 <<< s), s = sum of the first r shifts.
  function automatic void build_model(input logic [63:0] key);
    logic [27:0] c0, d0, cr, dr;
    logic [55:0] cd;
    logic [47:0] k;
    int sh;
    for (int j = 0; j < 28; j++) begin
      c0[27-j] = key[64-PC1_T[j]];
      d0[27-j] = key[64-PC1_T[28+j]];
    end
    sh = 0;
    for (int r = 0; r < 16; r++) begin
      sh = sh + SCHED_T[r];
      for (int p = 1; p <= 28; p++) begin
        cr[28-p] = c0[28-(((p-1+sh) % 28)+1)];
        dr[28-p] = d0[28-(((p-1+sh) % 28)+1)];
      end
      cd = {cr, dr};
      for (int j = 0; j < 48; j++) k[47-j] = cd[56-PC2_T[j]];
      exp_ks[r] = k;
    end
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // Issue a start from IDLE, then scramble key/direction to show RUN ignores them.
  task automatic start(input logic [63:0] key, input logic dec);
    i_key = key;
    i_decrypt = dec;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    i_key = {$urandom, $urandom};
    i_decrypt = 1'($urandom_range(1));
    chk("start_latency_valid", 64'(o_valid), 64'd1);
  endtask

  // Accept until the sequence ends, then step past the done cycle.
  task automatic drain();
    int cyc = 0;
    i_ready = 1'b1;
    while (o_valid && cyc < 40) begin
      tick();
      cyc++;
    end
    i_ready = 1'b0;
    chk("drain_ends", 64'(o_valid), 64'd0);
    tick();
  endtask

  // Full sequence with ready asserted pct% of the time and random i_start noise.
  task automatic do_seq(input logic [63:0] key, input logic dec, input int pct);
    int beats = 0;
    int cyc = 0;
    int idx;
    build_model(key);
    start(key, dec);
    while (beats < 16 && cyc < 600 && o_valid) begin
      idx = dec ? 15 - beats : beats;
      chk("seq_subkey", 64'(o_subkey), 64'(exp_ks[idx]));
      chk("seq_round", 64'(o_round), 64'(idx));
      chk("seq_busy", 64'(o_busy), 64'd1);
      i_ready = ($urandom_range(99) < pct);
      i_start = 1'($urandom_range(1));
      tick();
      cyc++;
      if (i_ready) beats++;
    end
    i_ready = 1'b0;
    i_start = 1'b0;
    chk("seq_handshakes", 64'(beats), 64'd16);
    chk("seq_end_valid", 64'(o_valid), 64'd0);
    chk("seq_end_done", 64'(o_done), 64'd1);
    tick();
    chk("seq_done_one_cycle", 64'(o_done), 64'd0);
  endtask

  typedef struct {
    logic [63:0] key;
    logic        dec;
    int          beat;
    logic [47:0] exp_subkey;
    logic [3:0]  exp_round;
  } vec_t;

  vec_t vecs [10];

  task automatic apply_vec(input int n, input vec_t v);
    start(v.key, v.dec);
    i_ready = 1'b1;
    for (int b = 0; b < v.beat; b++) tick();
    i_ready = 1'b0;
    tick();   // one stalled cycle: value must hold
    chk($sformatf("vec%0d_subkey", n), 64'(o_subkey), 64'(v.exp_subkey));
    chk($sformatf("vec%0d_round", n), 64'(o_round), 64'(v.exp_round));
    drain();
  endtask

  initial begin
    i_rst_n = 1'b0;
    i_start = 1'b0;
    i_key = '0;
    i_decrypt = 1'b0;
    i_ready = 1'b0;
    i_abort = 1'b0;

    vecs[0] = '{K0, 1'b0, 0,  48'h1B02EFFC7072, 4'd0};
    vecs[1] = '{K0, 1'b0, 1,  48'h79AED9DBC9E5, 4'd1};
    vecs[2] = '{K0, 1'b0, 2,  48'h55FC8A42CF99, 4'd2};
    vecs[3] = '{K0, 1'b0, 14, 48'hBF918D3D3F0A, 4'd14};
    vecs[4] = '{K0, 1'b0, 15, 48'hCB3D8B0E17F5, 4'd15};
    vecs[5] = '{K0, 1'b1, 0,  48'hCB3D8B0E17F5, 4'd15};
    vecs[6] = '{K0, 1'b1, 1,  48'hBF918D3D3F0A, 4'd14};
    vecs[7] = '{K0, 1'b1, 13, 48'h55FC8A42CF99, 4'd2};
    vecs[8] = '{K0, 1'b1, 14, 48'h79AED9DBC9E5, 4'd1};
    vecs[9] = '{K0, 1'b1, 15, 48'h1B02EFFC7072, 4'd0};

    // Reset state.
    #3;
    chk("rst_valid", 64'(o_valid), 64'd0);
    chk("rst_busy", 64'(o_busy), 64'd0);
    chk("rst_done", 64'(o_done), 64'd0);
    chk("rst_round", 64'(o_round), 64'd0);
    chk("rst_subkey", 64'(o_subkey), 64'd0);
    tick();
    tick();
    i_rst_n = 1'b1;
    tick();
    chk("idle_after_rst", 64'(o_valid), 64'd0);

    // Known-answer table.
    for (int n = 0; n < 10; n++) apply_vec(n, vecs[n]);

    // Full known-key sequences, ready held high.
    do_seq(K0, 1'b0, 100);
    do_seq(K0, 1'b1, 100);

    // i_start held high: back-to-back sequences with one done cycle between.
    build_model(K0);
    i_key = K0;
    i_decrypt = 1'b0;
    i_start = 1'b1;
    i_ready = 1'b1;
    tick();
    for (int s = 0; s < 2; s++) begin
      for (int b = 0; b < 16; b++) begin
        chk("b2b_valid", 64'(o_valid), 64'd1);
        chk("b2b_subkey", 64'(o_subkey), 64'(exp_ks[b]));
        chk("b2b_round", 64'(o_round), 64'(b));
        tick();
      end
      chk("b2b_gap_valid", 64'(o_valid), 64'd0);
      chk("b2b_gap_done", 64'(o_done), 64'd1);
      if (s == 1) i_start = 1'b0;
      tick();
    end
    chk("b2b_stops", 64'(o_valid), 64'd0);
    i_ready = 1'b0;
    tick();

    // Abort after 5 handshakes; abort wins over a same-cycle handshake.
    build_model(K0);
    start(K0, 1'b0);
    i_ready = 1'b1;
    repeat (5) tick();
    chk("abort_pre_round", 64'(o_round), 64'd5);
    chk("abort_pre_subkey", 64'(o_subkey), 64'(exp_ks[5]));
    i_abort = 1'b1;
    tick();
    i_abort = 1'b0;
    i_ready = 1'b0;
    chk("abort_valid", 64'(o_valid), 64'd0);
    chk("abort_busy", 64'(o_busy), 64'd0);
    chk("abort_no_done", 64'(o_done), 64'd0);
    tick();
    chk("abort_no_done_later", 64'(o_done), 64'd0);
    // Abort in IDLE must not block a start; restart begins at K1.
    i_abort = 1'b1;
    i_key = K0;
    i_decrypt = 1'b0;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    i_abort = 1'b0;
    chk("restart_valid", 64'(o_valid), 64'd1);
    chk("restart_subkey", 64'(o_subkey), 64'(exp_ks[0]));
    chk("restart_round", 64'(o_round), 64'd0);
    drain();

    // Reset mid-sequence after 7 beats.
    build_model(64'h0E329232EA6D0D73);
    start(64'h0E329232EA6D0D73, 1'b0);
    i_ready = 1'b1;
    repeat (7) tick();
    i_ready = 1'b0;
    chk("mid_round", 64'(o_round), 64'd7);
    chk("mid_subkey", 64'(o_subkey), 64'(exp_ks[7]));
    #2 i_rst_n = 1'b0;
    #1;
    chk("arst_valid", 64'(o_valid), 64'd0);
    chk("arst_busy", 64'(o_busy), 64'd0);
    chk("arst_round", 64'(o_round), 64'd0);
    chk("arst_subkey", 64'(o_subkey), 64'd0);
    chk("arst_done", 64'(o_done), 64'd0);
    tick();
    #2 i_rst_n = 1'b1;
    i_ready = 1'b1;
    tick();
    chk("post_rst_no_beat", 64'(o_valid), 64'd0);
    chk("post_rst_no_done", 64'(o_done), 64'd0);
    i_ready = 1'b0;
    do_seq(64'h0E329232EA6D0D73, 1'b0, 100);

    // Random keys and directions with ~50% backpressure.
    for (int n = 0; n < 1000; n++) begin
      do_seq({$urandom, $urandom}, 1'($urandom_range(1)), 50);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/des_key_sched.md
DES_KEY_SCHED -- requirements
Module: des_key_sched

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed by DES.
REQ-002 i_clk  input  1  single clock for all state; rising-edge.
REQ-003 i_rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 i_start  input  1  request a new 16-subkey sequence; sampled only in IDLE.
REQ-005 i_key  input  64  DES key, bit 1 (FIPS numbering) = i_key[63]; parity bits 8,16,..,64 ignored.
REQ-006 i_decrypt  input  1  sampled with i_start; 0 = emit K1..K16, 1 = emit K16..K1.
REQ-007 i_ready  input  1  consumer accepts o_subkey this cycle.
REQ-008 i_abort  input  1  synchronous abort of a running sequence.
REQ-009 o_subkey  output  48  current subkey, bit 1 of PC-2 output = o_subkey[47].
REQ-010 o_valid  output  1  o_subkey and o_round are valid.
REQ-011 o_round  output  4  index of the emitted subkey, 0..15 = K1..K16.
REQ-012 o_busy  output  1  high in RUN.
REQ-013 o_done  output  1  one-cycle pulse after the 16th subkey is accepted.

Function
REQ-014 The FSM SHALL have states IDLE and RUN only.
REQ-015 In IDLE with i_start=1, the block SHALL load C/D (28 bits each) from PC-1(i_key), latch i_decrypt, and go to RUN next cycle.
REQ-016 Encrypt: on load, C/D SHALL be left-rotated by 1 so the first emitted value is K1; each accepted handshake SHALL left-rotate by the next schedule entry 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
REQ-017 Decrypt: on load, C/D SHALL NOT rotate (C0/D0 yields K16); each accepted handshake SHALL right-rotate by 1,2,2,2,2,2,2,1,2,2,2,2,2,2,1 in sequence.
REQ-018 o_subkey SHALL be PC-2 applied combinationally to the registered C/D; o_valid SHALL equal (state==RUN).
REQ-019 Latency: o_valid SHALL rise exactly 1 cycle after i_start is sampled in IDLE.
REQ-020 A handshake occurs when o_valid & i_ready; without a handshake C/D, o_round and o_subkey SHALL hold stable.
REQ-021 o_round SHALL be 15 - step in decrypt and step in encrypt, where step counts accepted handshakes (0..15).
REQ-022 The 16th handshake SHALL return the FSM to IDLE and pulse o_done for one cycle; o_valid SHALL be 0 that cycle.
REQ-023 i_start in RUN SHALL be ignored; i_key/i_decrypt changes in RUN SHALL have no effect.
REQ-024 i_abort in RUN SHALL force IDLE next cycle with no o_done pulse, and takes priority over a same-cycle handshake; i_abort in IDLE has no effect.
REQ-025 i_start and i_done-cycle coincidence: i_start asserted in the cycle o_done pulses (IDLE) SHALL be accepted.

Reset
REQ-026 While i_rst_n=0: state=IDLE, C/D=0, step=0, decrypt flag=0, o_valid=0, o_busy=0, o_done=0, o_round=0, o_subkey=PC-2(0)=0.
REQ-027 Reset asserted mid-sequence SHALL abandon it immediately, without o_done; no handshake SHALL be seen until a new i_start.

Structure
REQ-028 PC-1 and PC-2 tables and the 16-entry shift schedule SHALL live in the shared package des_pkg, alongside existing DES tables.
REQ-029 PC-2 SHALL be a separate combinational sub-module des_pc2 (56 in, 48 out), reusable by other DES blocks.

Verification
REQ-030 Key 133457799BBCDFF1, encrypt, i_ready held 1 -> o_valid 1 cycle after start, K1=1B02EFFC7072 with o_round=0, K16=CB3D8B0E17F5 with o_round=15 on 16th beat, o_done next cycle.
REQ-031 Same key, decrypt -> first subkey CB3D8B0E17F5 (o_round=15), last 1B02EFFC7072 (o_round=0); full sequence equals the encrypt sequence reversed.
REQ-032 Random i_ready backpressure (~50%) over 1000 random keys -> subkeys match a reference model, stable while i_ready=0, exactly 16 handshakes per sequence.
REQ-033 i_abort after 5th handshake -> IDLE next cycle, no o_done; new i_start then restarts at K1 (encrypt).
REQ-034 i_rst_n pulsed low mid-sequence (after 7 beats) -> all outputs 0 asynchronously; subsequent start yields the correct full sequence.
REQ-035 i_start held high continuously -> back-to-back sequences with one idle (o_done) cycle between them; i_start pulses during RUN ignored.
